// File: rtl/gobou.sv
// -----------------------------------------------------------------------------
// gobou - fully connected neural-network layer engine.
//
// Purpose:
//   Computes one fully connected layer in fixed point. Inputs are read from an
//   image memory, CORE neurons are evaluated in parallel per group, and the
//   saturated results are written back into the same image memory.
//
// Configuration macro:
//   GOBOU_RELU_EN - when defined, negative saturated results are written as 0.
//                   When undefined, signed results are written unchanged.
//
// Ports:
//   clk          in   sole clock, rising edge
//   xrst         in   asynchronous active-high reset
//   req          in   one-cycle start pulse (ignored while busy)
//   img_we       in   host image write enable (ignored while busy)
//   input_addr   in   host access address / input-vector base on start
//   output_addr  in   output-vector base address, latched on start
//   write_img    in   host image write data
//   net_we       in   0 = no write, n+1 = write weight memory of core n
//   net_addr     in   host weight write address
//   write_net    in   host weight write data
//   total_out    in   number of output neurons
//   total_in     in   number of inputs per neuron
//   ack          out  1 = idle/done, 0 = busy
//   read_img     out  registered image word at input_addr
//
// Handshake: the host pulses req for one cycle while ack=1; ack drops on the
// following cycle and rises again once every output word has been written.
// -----------------------------------------------------------------------------

// Image memory: one write port, two registered read ports. Port A serves the
// host (read_img) and is cleared by reset; port B feeds the MAC pipeline.
module gobou_mem_img #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_a_o <= '0;
        end else begin
            rdata_a_o <= mem[raddr_a_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_b_o <= mem[raddr_b_i];
    end
endmodule

// Per-core weight memory: one write port, one registered read port.
module gobou_mem_net #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end
endmodule

module gobou #(
    parameter int DWIDTH  = 16,
    parameter int IMGSIZE = 12,
    parameter int NETSIZE = 16,
    parameter int CORE    = 8,
    parameter int CORELOG = 3,
    parameter int LWIDTH  = 10,
    parameter int FRAC    = 8
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      req,
    input  logic                      img_we,
    input  logic [IMGSIZE-1:0]        input_addr,
    input  logic [IMGSIZE-1:0]        output_addr,
    input  logic signed [DWIDTH-1:0]  write_img,
    input  logic [CORELOG:0]          net_we,
    input  logic [NETSIZE-1:0]        net_addr,
    input  logic signed [DWIDTH-1:0]  write_net,
    input  logic [LWIDTH-1:0]         total_out,
    input  logic [LWIDTH-1:0]         total_in,
    output logic                      ack,
    output logic signed [DWIDTH-1:0]  read_img
);
    localparam int ACCW = 2*DWIDTH + LWIDTH;
    localparam int NW   = LWIDTH + 1;   // neuron index width, room for CORE*(g+1)

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_ACCUM  = 2'd1,
        S_BIAS   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LWIDTH-1:0]   tin_q, tin_d;
    logic [LWIDTH-1:0]   tout_q, tout_d;
    logic [IMGSIZE-1:0]  in_base_q, in_base_d;
    logic [IMGSIZE-1:0]  out_base_q, out_base_d;
    logic [LWIDTH-1:0]   cnt_q, cnt_d;       // input index i within a group
    logic [CORELOG-1:0]  jcnt_q, jcnt_d;     // output core index j
    logic [NW-1:0]       nbase_q, nbase_d;   // CORE*g
    logic [NETSIZE-1:0]  wbase_q, wbase_d;   // (total_in+1)*g
    logic                mac_v_q, mac_v_d;   // memory read data is a valid MAC operand pair
    logic                acc_clr;

    logic signed [ACCW-1:0]   acc_q [CORE];
    logic signed [ACCW-1:0]   acc_d [CORE];
    logic [DWIDTH-1:0]        res_q [CORE];
    logic [DWIDTH-1:0]        res_d [CORE];
    logic signed [DWIDTH-1:0] w_rd  [CORE];
    logic signed [2*DWIDTH-1:0] prod [CORE];

    logic                     host_idle;
    logic                     eng_we;
    logic [IMGSIZE-1:0]       eng_waddr;
    logic [NW-1:0]            nidx;
    logic [NW-1:0]            nnext;
    logic                     mem_we;
    logic [IMGSIZE-1:0]       mem_waddr;
    logic [DWIDTH-1:0]        mem_wdata;
    logic [IMGSIZE-1:0]       img_raddr;
    logic [DWIDTH-1:0]        img_rd_raw;
    logic signed [DWIDTH-1:0] img_rd;
    logic [DWIDTH-1:0]        read_img_raw;
    logic [NETSIZE-1:0]       w_raddr;

    assign host_idle = (state_q == S_WAIT);
    assign ack       = host_idle;

    // cnt saturates at total_in, so the same address expression covers both
    // the weight stream (i < total_in) and the bias fetch (i == total_in).
    assign img_raddr = in_base_q + IMGSIZE'(cnt_q);
    assign w_raddr   = wbase_q + NETSIZE'(cnt_q);

    assign nidx      = nbase_q + NW'(jcnt_q);
    assign nnext     = nbase_q + NW'(CORE);
    assign eng_waddr = out_base_q + IMGSIZE'(nidx);

    assign mem_we    = eng_we | (host_idle & img_we);
    assign mem_waddr = eng_we ? eng_waddr : input_addr;
    assign mem_wdata = eng_we ? res_q[jcnt_q] : write_img;

    gobou_mem_img #(
        .DW (DWIDTH),
        .AW (IMGSIZE)
    ) mem_img (
        .clk_i     (clk),
        .rst_i     (xrst),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (input_addr),
        .rdata_a_o (read_img_raw),
        .raddr_b_i (img_raddr),
        .rdata_b_o (img_rd_raw)
    );

    assign read_img = read_img_raw;
    assign img_rd   = img_rd_raw;

    for (genvar j = 0; j < CORE; j++) begin : g_core
        logic [DWIDTH-1:0] w_raw;
        logic              w_we;

        assign w_we = host_idle && (net_we == (CORELOG+1)'(j + 1));

        gobou_mem_net #(
            .DW (DWIDTH),
            .AW (NETSIZE)
        ) mem_net (
            .clk_i   (clk),
            .we_i    (w_we),
            .waddr_i (net_addr),
            .wdata_i (write_net),
            .raddr_i (w_raddr),
            .rdata_o (w_raw)
        );

        assign w_rd[j] = w_raw;
        assign prod[j] = img_rd * w_rd[j];
    end

    // (acc >>> FRAC) + bias, saturated to the signed DWIDTH range.
    function automatic logic [DWIDTH-1:0] sat_bias(input logic signed [ACCW-1:0] a,
                                                   input logic signed [DWIDTH-1:0] b);
        logic signed [ACCW-1:0] sh;
        logic signed [ACCW-1:0] bx;
        logic signed [ACCW-1:0] s;
        logic [DWIDTH-1:0]      r;
        sh = a >>> FRAC;
        bx = {{(ACCW-DWIDTH){b[DWIDTH-1]}}, b};
        s  = sh + bx;
        if (!s[ACCW-1] && (|s[ACCW-2:DWIDTH-1])) begin
            r = {1'b0, {(DWIDTH-1){1'b1}}};
        end else if (s[ACCW-1] && !(&s[ACCW-2:DWIDTH-1])) begin
            r = {1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            r = s[DWIDTH-1:0];
        end
`ifdef GOBOU_RELU_EN
        if (r[DWIDTH-1]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    // Control FSM
    always_comb begin
        state_d    = state_q;
        tin_d      = tin_q;
        tout_d     = tout_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        cnt_d      = cnt_q;
        jcnt_d     = jcnt_q;
        nbase_d    = nbase_q;
        wbase_d    = wbase_q;
        mac_v_d    = 1'b0;
        acc_clr    = 1'b0;
        eng_we     = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (req) begin
                    tin_d      = total_in;
                    tout_d     = total_out;
                    in_base_d  = input_addr;
                    out_base_d = output_addr;
                    cnt_d      = '0;
                    nbase_d    = '0;
                    wbase_d    = '0;
                    acc_clr    = 1'b1;
                    if (total_out == '0) begin
                        // Empty layer: pass through the last output slot so
                        // nothing is written and the machine returns at once.
                        jcnt_d  = CORELOG'(CORE - 1);
                        state_d = S_OUTPUT;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end

            S_ACCUM: begin
                // Reads issued here return next cycle together with mac_v.
                // The cycle with cnt == total_in absorbs the last product and
                // fetches the bias.
                if (cnt_q < tin_q) begin
                    mac_v_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = S_BIAS;
                end
            end

            S_BIAS: begin
                jcnt_d  = '0;
                state_d = S_OUTPUT;
            end

            S_OUTPUT: begin
                eng_we = (nidx < NW'(tout_q));
                if (jcnt_q == CORELOG'(CORE - 1)) begin
                    if (nnext < NW'(tout_q)) begin
                        nbase_d = nnext;
                        wbase_d = wbase_q + NETSIZE'(tin_q) + NETSIZE'(1);
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    jcnt_d = jcnt_q + 1'b1;
                end
            end

            default: state_d = S_WAIT;
        endcase
    end

    // Datapath: per-core accumulate and result capture
    always_comb begin
        for (int j = 0; j < CORE; j++) begin
            acc_d[j] = acc_q[j];
            res_d[j] = res_q[j];
            if (acc_clr) begin
                acc_d[j] = '0;
            end else if (mac_v_q) begin
                acc_d[j] = acc_q[j] + {{(ACCW-2*DWIDTH){prod[j][2*DWIDTH-1]}}, prod[j]};
            end
            if (state_q == S_BIAS) begin
                res_d[j] = sat_bias(acc_q[j], w_rd[j]);
            end
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q    <= S_WAIT;
            tin_q      <= '0;
            tout_q     <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            cnt_q      <= '0;
            jcnt_q     <= '0;
            nbase_q    <= '0;
            wbase_q    <= '0;
            mac_v_q    <= 1'b0;
            for (int j = 0; j < CORE; j++) begin
                acc_q[j] <= '0;
                res_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tin_q      <= tin_d;
            tout_q     <= tout_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            cnt_q      <= cnt_d;
            jcnt_q     <= jcnt_d;
            nbase_q    <= nbase_d;
            wbase_q    <= wbase_d;
            mac_v_q    <= mac_v_d;
            for (int j = 0; j < CORE; j++) begin
                acc_q[j] <= acc_d[j];
                res_q[j] <= res_d[j];
            end
        end
    end
endmodule

// File: tb/tb_gobou.sv
// -----------------------------------------------------------------------------
// tb_gobou - directed self-checking bench for gobou.
// Expected values are hand-computed constants, or come from a small reference
// formula for the generated layer.
// -----------------------------------------------------------------------------
module tb_gobou;
    logic               clk = 1'b0;
    logic               xrst;
    logic               req;
    logic               img_we;
    logic [11:0]        input_addr;
    logic [11:0]        output_addr;
    logic signed [15:0] write_img;
    logic [3:0]         net_we;
    logic [15:0]        net_addr;
    logic signed [15:0] write_net;
    logic [9:0]         total_out;
    logic [9:0]         total_in;
    logic               ack;
    logic signed [15:0] read_img;

    int n_tests = 0;
    int n_fail  = 0;

    gobou dut (
        .clk         (clk),
        .xrst        (xrst),
        .req         (req),
        .img_we      (img_we),
        .input_addr  (input_addr),
        .output_addr (output_addr),
        .write_img   (write_img),
        .net_we      (net_we),
        .net_addr    (net_addr),
        .write_net   (write_net),
        .total_out   (total_out),
        .total_in    (total_in),
        .ack         (ack),
        .read_img    (read_img)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic wr_img(input int a, input int d);
        input_addr = 12'(a);
        write_img  = 16'(d);
        img_we     = 1'b1;
        tick();
        img_we     = 1'b0;
    endtask

    task automatic wr_net(input int core, input int a, input int d);
        net_we    = 4'(core + 1);
        net_addr  = 16'(a);
        write_net = 16'(d);
        tick();
        net_we    = 4'd0;
    endtask

    task automatic rd_img(input int a, output logic [15:0] v);
        input_addr = 12'(a);
        tick();
        v = read_img;
    endtask

    task automatic start(input int tin, input int tout, input int ia, input int oa);
        total_in    = 10'(tin);
        total_out   = 10'(tout);
        input_addr  = 12'(ia);
        output_addr = 12'(oa);
        req         = 1'b1;
        tick();
        req         = 1'b0;
        check("ack_low_after_req", 16'(ack), 16'd0);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int c;
        c = 0;
        while (ack !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        check(tag, 16'(ack), 16'd1);
    endtask

    // Reference model for the generated layer
    function automatic int xv(int i);
        return (((i * 97) % 200) - 100) * 16;
    endfunction

    function automatic int wv(int n, int i);
        return (((n * 7 + i * 13) % 61) - 30) * 8;
    endfunction

    function automatic int bv(int n);
        return n * 16 - 100;
    endfunction

    function automatic logic [15:0] golden(int n, int tin);
        longint acc;
        longint s;
        acc = 0;
        for (int i = 0; i < tin; i++) begin
            acc += longint'(xv(i)) * longint'(wv(n, i));
        end
        s = (acc >>> 8) + longint'(bv(n));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`ifdef GOBOU_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic load_layer(input int tin, input int tout, input int ia);
        for (int i = 0; i < tin; i++) begin
            wr_img(ia + i, xv(i));
        end
        for (int n = 0; n < tout; n++) begin
            for (int i = 0; i < tin; i++) begin
                wr_net(n % 8, (tin + 1) * (n / 8) + i, wv(n, i));
            end
            wr_net(n % 8, (tin + 1) * (n / 8) + tin, bv(n));
        end
    endtask

    // Directed sequence
    initial begin
        logic [15:0] v;
        xrst = 1'b1; req = 1'b0; img_we = 1'b0; input_addr = '0; output_addr = '0;
        write_img = '0; net_we = '0; net_addr = '0; write_net = '0;
        total_out = '0; total_in = '0;

        // Reset state
        tick(); tick();
        check("reset_ack", 16'(ack), 16'd1);
        check("reset_read_img", read_img, 16'h0000);
        xrst = 1'b0;
        tick();

        // Host write / read
        wr_img(5, 16'h1234);
        rd_img(5, v);
        check("host_rw", v, 16'h1234);

        // Simple layer: (256*256 + 512*256) >>> 8 + 256 = 1024
        wr_img(100, 256); wr_img(101, 512); wr_img(201, 16'h7777);
        wr_net(0, 0, 256); wr_net(0, 1, 256); wr_net(0, 2, 256);
        start(2, 1, 100, 200);
        wait_ack("simple_ack", 25);
        rd_img(200, v); check("simple_result", v, 16'd1024);
        rd_img(201, v); check("simple_no_spill", v, 16'h7777);

        // Positive saturation
        wr_img(300, 16'h7fff); wr_img(301, 16'h7fff);
        wr_net(0, 0, 16'h7fff); wr_net(0, 1, 16'h7fff); wr_net(0, 2, 0);
        start(2, 1, 300, 210);
        wait_ack("satpos_ack", 25);
        rd_img(210, v); check("sat_pos", v, 16'h7fff);

        // Negative sum: -131072 >>> 8 = -512
        wr_img(300, 256); wr_img(301, 256);
        wr_net(0, 0, -256); wr_net(0, 1, -256); wr_net(0, 2, 0);
        start(2, 1, 300, 211);
        wait_ack("neg_ack", 25);
        rd_img(211, v);
`ifdef GOBOU_RELU_EN
        check("neg_relu", v, 16'h0000);
`else
        check("neg_signed", v, 16'hfe00);
`endif

        // Negative saturation
        wr_img(300, 16'h7fff); wr_img(301, 16'h7fff);
        wr_net(0, 0, 16'h8000); wr_net(0, 1, 16'h8000); wr_net(0, 2, 0);
        start(2, 1, 300, 212);
        wait_ack("satneg_ack", 25);
        rd_img(212, v);
`ifdef GOBOU_RELU_EN
        check("sat_neg_relu", v, 16'h0000);
`else
        check("sat_neg", v, 16'h8000);
`endif

        // total_in = 0 gives the bias
        wr_net(0, 0, 123);
        start(0, 1, 300, 220);
        wait_ack("tin0_ack", 23);
        rd_img(220, v); check("tin0_bias", v, 16'd123);

        // total_out = 0: no write, ack back within 4 cycles of req
        wr_img(230, 16'h4444);
        start(0, 0, 300, 230);
        wait_ack("tout0_ack", 3);
        rd_img(230, v); check("tout0_no_write", v, 16'h4444);

        // Layer of 5 inputs x 20 outputs, output range wraps past 4095
        wr_img(9, 16'h5a5a); wr_img(50, 16'h0f0f);
        load_layer(5, 20, 400);
        start(5, 20, 400, 4085);
        for (int k = 0; k < 10; k++) tick();
        // Requests and host writes while busy must be ignored
        total_out = 10'd1; output_addr = 12'd50; input_addr = 12'd50;
        write_img = 16'hdead; img_we = 1'b1; req = 1'b1;
        tick();
        img_we = 1'b0; req = 1'b0;
        wait_ack("layer_ack", 70);
        for (int n = 0; n < 20; n++) begin
            rd_img((4085 + n) % 4096, v);
            check($sformatf("layer_n%0d", n), v, golden(n, 5));
        end
        rd_img(9, v);  check("layer_unchanged_end", v, 16'h5a5a);
        rd_img(50, v); check("busy_ignored", v, 16'h0f0f);

        // Abort mid-run, then a clean rerun
        wr_img(700, 16'h3333);
        start(5, 20, 400, 700);
        tick(); tick(); tick();
        xrst = 1'b1;
        #1;
        check("abort_ack", 16'(ack), 16'd1);
        tick();
        xrst = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
        check("abort_idle", 16'(ack), 16'd1);
        rd_img(700, v); check("abort_no_write", v, 16'h3333);
        start(5, 20, 400, 700);
        wait_ack("rerun_ack", 70);
        rd_img(700, v); check("rerun_n0", v, golden(0, 5));
        rd_img(708, v); check("rerun_n8", v, golden(8, 5));
        rd_img(719, v); check("rerun_n19", v, golden(19, 5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gobou.md
GOBOU -- requirements
Module: gobou

Interface
REQ-001 Parameters: DWIDTH 16, data word width; IMGSIZE 12, image memory address width; NETSIZE 16, weight memory address width; CORE 8, parallel neuron cores; CORELOG 3, equal to log2(CORE); LWIDTH 10, layer-size width; FRAC 8, fixed-point fraction bits.
REQ-002 Ports, one per line:
- clk  in  1  sole clock; all logic on the rising edge.
- xrst  in  1  reset, asynchronous, active-high.
- req  in  1  one-cycle start pulse.
- img_we  in  1  host write enable for the image memory.
- input_addr  in  IMGSIZE  host access address; input-vector base address on start.
- output_addr  in  IMGSIZE  output-vector base address, latched on start.
- write_img  in  DWIDTH signed  host image write data.
- net_we  in  CORELOG+1  0 = no write; value n+1 writes the weight memory of core n.
- net_addr  in  NETSIZE  host weight write address.
- write_net  in  DWIDTH signed  host weight write data.
- total_out  in  LWIDTH  number of output neurons.
- total_in  in  LWIDTH  number of inputs per neuron.
- ack  out  1  1 = idle/done, 0 = busy.
- read_img  out  DWIDTH signed  image memory word at input_addr, registered.
REQ-003 The image memory SHALL be a submodule instance named mem_img whose storage array is named mem, with 2**IMGSIZE words.

Function
REQ-004 Host writes to the image memory SHALL be synchronous: when idle and img_we=1, mem[input_addr] <= write_img; img_we SHALL be ignored while busy.
REQ-005 Host writes to weights SHALL be synchronous: when idle and net_we=n+1 with n<CORE, the weight memory of core n at net_addr <= write_net; net_we values above CORE SHALL be ignored.
REQ-006 read_img SHALL equal mem[input_addr], one cycle after the address is presented.
REQ-007 Weight layout: for group g, core j holds neuron CORE*g+j at offsets (total_in+1)*g+i for i = 0..total_in-1, with the bias at offset (total_in+1)*g+total_in.
REQ-008 The state machine SHALL have the states S_WAIT, S_ACCUM, S_BIAS and S_OUTPUT.
REQ-009 S_WAIT SHALL go to S_ACCUM when req=1; ack SHALL be 0 from the following cycle, and total_in, total_out, input_addr and output_addr SHALL be latched.
REQ-010 S_ACCUM SHALL step i from 0 to total_in-1; each core SHALL add the signed product image[in_base+i]*w_j[i] to a 2*DWIDTH+LWIDTH-bit signed accumulator cleared at group start.
REQ-011 S_BIAS SHALL compute result_j = (acc_j >>> FRAC) + bias_j, saturated to the signed DWIDTH range.
REQ-012 S_OUTPUT SHALL write result_j to image[out_base+CORE*g+j], one word per cycle in ascending j, and SHALL skip any j with CORE*g+j >= total_out.
REQ-013 After S_OUTPUT, the next group SHALL start while CORE*(g+1) < total_out; otherwise the machine SHALL return to S_WAIT with ack=1.
REQ-014 Pipeline latency between memory reads and MAC is implementation-defined, but ack SHALL rise no later than ceil(total_out/CORE)*(total_in+CORE+8)+8 cycles after req.
REQ-015 req SHALL be ignored while busy.
REQ-016 total_in=0 SHALL give result = bias.
REQ-017 total_out=0 SHALL give no writes, with ack returning within 4 cycles.
REQ-018 Address arithmetic SHALL wrap modulo the memory size.

Reset
REQ-019 When xrst=1: state SHALL become S_WAIT, ack 1, read_img 0, and all counters and accumulators 0.
REQ-020 Memory contents SHALL NOT be cleared by reset.
REQ-021 Reset during operation SHALL abort the operation immediately with no further writes.

Configuration
REQ-022 With macro GOBOU_RELU_EN defined, negative saturated results SHALL be written as 0.
REQ-023 Without GOBOU_RELU_EN, signed results SHALL be written unchanged.

Verification
REQ-024 Reset check: xrst=1 -> ack=1 and read_img=0.
REQ-025 Host write/read: img_we=1, input_addr=5, write_img=0x1234 -> read_img=0x1234 one cycle after input_addr=5 is presented.
REQ-026 Simple layer: total_in=2, total_out=1, inputs 256,512 (1.0,2.0), core 0 weights 256,256, bias 256 -> image[output_addr]=1024.
REQ-027 Saturation and ReLU: large positive products -> 32767; negative sum -> 0 with GOBOU_RELU_EN, negative value without it.
REQ-028 Full layer: total_in=800, total_out=500, output_addr=1000 -> 500 words match a golden model; image[1500] unchanged (partial last group of 4 cores).
REQ-029 Abort and ignored requests: req while busy -> no effect; xrst mid-run -> ack=1 next cycle, and a new run completes correctly.
